fetch_pc: RTL and testbench
===========================

# fetch_pc

Instruction-fetch stage of the Hack CPU: a 16-bit program counter built on the same load-gated register semantics as the single-bit storage cell. It drives the combinational ROM32K address, captures the returned word into an instruction register with a valid flag, and accepts jump redirects and stalls from the CPU. It sits between the ROM and the decode/execute logic, and flags out-of-range fetches.

## Interface
- `WIDTH`, 16, PC and instruction width
- `ADDR_W`, 15, ROM address width (32K words)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces all state to reset values
- `clear`  in  1  synchronous restart (Hack "reset" button semantics)
- `load`  in  1  jump: redirect PC to `in`
- `in`  in  WIDTH  jump target
- `stall`  in  1  downstream not ready; hold fetch state
- `rom_addr`  out  ADDR_W  = `pc_q[ADDR_W-1:0]`, combinational
- `rom_data`  in  WIDTH  ROM word at `rom_addr`, same cycle
- `instr`  out  WIDTH  registered instruction
- `instr_pc`  out  WIDTH  address `instr` was fetched from
- `instr_valid`  out  1  `instr` is a live instruction
- `fault`  out  1  sticky: fetch attempted at `pc_q >= 2**ADDR_W`

## Operation
- Internal state: `pc_q` (WIDTH), FSM state ∈ {RUN, FAULT}.
- Reset values (async `reset`): `pc_q=0`, `instr=0`, `instr_pc=0`, `instr_valid=0`, `fault=0`, state RUN.
- Per-edge priority: `clear` > FAULT hold > `load` > `stall` > fetch.
  - `clear` (any state): `pc_q<=0`, `instr_valid<=0`, `fault<=0`, state<=RUN. `instr`/`instr_pc` hold.
  - FAULT: all registers hold. `load` and `stall` are ignored. Only `clear` or `reset` exits.
  - RUN, `load`: `pc_q<=in`, `instr_valid<=0` (bubble discards the sequential fetch). `instr`/`instr_pc` hold. `load` overrides `stall`.
  - RUN, `stall`: `pc_q`, `instr`, `instr_pc`, `instr_valid` all hold.
  - RUN, fetch with `pc_q[WIDTH-1:ADDR_W] != 0`: state<=FAULT, `fault<=1`, `instr_valid<=0`, `pc_q` holds.
  - RUN, fetch in range: `instr<=rom_data`, `instr_pc<=pc_q`, `instr_valid<=1`, `pc_q<=pc_q+1` (mod 2**WIDTH).
- Arithmetic: increment is WIDTH bits, unsigned. 0x7FFF+1=0x8000, which faults on the next fetch rather than wrapping the ROM address. 0xFFFF+1=0 is reachable only if `pc_q` is loaded there, and that value faults first.
- `rom_addr` always reflects `pc_q`, including during stall and FAULT.

## Timing
- Fetch latency: one edge. `pc_q=a` at edge k gives `instr=ROM[a]`, `instr_pc=a`, `instr_valid=1` after edge k.
- Throughput: one instruction per cycle when `stall=0`.
- First edge after `reset` deasserts (no `clear`/`stall`): `instr=ROM[0]`, valid.
- Redirect penalty: exactly one invalid cycle. Load at edge k leaves `instr_valid=0` after k. Edge k+1 yields `ROM[in]` with `instr_pc=in`.
- Stall is level-sensitive, effective at the sampling edge, with no skid. Deasserting it resumes fetch from the held `pc_q` on the next edge.
- `clear` is followed by one invalid cycle; the next edge fetches `ROM[0]`.
- `reset` asserted mid-stream takes effect immediately, without waiting for an edge. No partial fetch completes.
- `load` and `clear` together: `clear` wins, `pc_q=0`.

## Test plan
- Sequential fetch: ROM[i]=0x1000+i, release reset, 5 edges -> `instr` = 0x1000..0x1004, `instr_pc` 0..4, `instr_valid=1` from first edge, `rom_addr=5`.
- Jump: at `pc_q=3` assert `load`, `in=0x0100` for one edge -> next cycle `instr_valid=0`. The following edge gives `instr=ROM[0x100]` with `instr_pc=0x0100`.
- Stall and load-over-stall:
  - `stall=1` for 3 edges at `pc_q=2` -> all outputs frozen. Release -> `instr=ROM[2]`.
  - `stall=1` with `load` (`in=7`) -> `pc_q=7`, bubble.
- Fault and wrap boundary:
  - Load `in=0x7FFE`, run -> ROM[0x7FFE], then ROM[0x7FFF] valid. Next edge: `fault=1`, `instr_valid=0`, `rom_addr` stays 0 with `pc_q` at 0x8000.
  - Assert `load` -> no effect.
  - Assert `clear` -> `fault=0`; the next edge fetches ROM[0].
- Clear priority: `clear` and `load` (`in=0x20`) on the same edge -> `pc_q=0`, `instr_valid=0`.
- Async reset: assert `reset` mid-cycle while fetching at `pc_q=9` -> all outputs zero before the next edge. Deassert -> ROM[0] on the first edge.

Source files
------------

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc
// Purpose  : Hack CPU fetch stage. It holds the PC, registers the ROM word it
//            fetches, and applies jump/stall/clear control plus a sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_in,
  input  logic              i_stall,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WIDTH-1:0]  i_rom_data,
  output logic [WIDTH-1:0]  o_instr,
  output logic [WIDTH-1:0]  o_instr_pc,
  output logic              o_instr_valid,
  output logic              o_fault
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_instr, w_instr_nxt;
  logic [WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_fault, w_fault_nxt;
  logic             w_out_of_range;

  // Any set bit above the ROM address field means the fetch falls outside ROM32K.
  assign w_out_of_range = |r_pc[WIDTH-1:ADDR_W];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_RUN;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_fault_nxt    = r_fault;
    if (i_clear) begin
      w_state_nxt = S_RUN;
      w_pc_nxt    = '0;
      w_valid_nxt = 1'b0;
      w_fault_nxt = 1'b0;
    end else if (r_state == S_RUN) begin
      if (i_load) begin
        // The jump bubbles the pipeline: the sequential word is dropped.
        w_pc_nxt    = i_in;
        w_valid_nxt = 1'b0;
      end else if (!i_stall) begin
        if (w_out_of_range) begin
          w_state_nxt = S_FAULT;
          w_fault_nxt = 1'b1;
          w_valid_nxt = 1'b0;
        end else begin
          w_instr_nxt    = i_rom_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + WIDTH'(1);
        end
      end
    end
  end

  assign o_rom_addr    = r_pc[ADDR_W-1:0];
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_valid;
  assign o_fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc
// Purpose  : Directed self-checking bench for fetch_pc with ROM[i] = 0x1000+i.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 15;

  logic              r_clk = 1'b0;
  logic              r_reset, r_clear, r_load, r_stall;
  logic [WIDTH-1:0]  r_in;
  logic [ADDR_W-1:0] w_rom_addr;
  logic [WIDTH-1:0]  w_rom_data, w_instr, w_instr_pc;
  logic              w_instr_valid, w_fault;

  int n_total = 0;
  int n_bad   = 0;

  always #5 r_clk = ~r_clk;

  assign w_rom_data = 16'h1000 + {1'b0, w_rom_addr};

  fetch_pc #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_dut (
    .i_clk        (r_clk),
    .i_reset      (r_reset),
    .i_clear      (r_clear),
    .i_load       (r_load),
    .i_in         (r_in),
    .i_stall      (r_stall),
    .o_rom_addr   (w_rom_addr),
    .i_rom_data   (w_rom_data),
    .o_instr      (w_instr),
    .o_instr_pc   (w_instr_pc),
    .o_instr_valid(w_instr_valid),
    .o_fault      (w_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ins, input logic [15:0] ipc,
                         input logic vld, input logic flt, input logic [14:0] addr);
    chk({tag, ".instr"}, 32'(w_instr), 32'(ins));
    chk({tag, ".instr_pc"}, 32'(w_instr_pc), 32'(ipc));
    chk({tag, ".valid"}, 32'(w_instr_valid), 32'(vld));
    chk({tag, ".fault"}, 32'(w_fault), 32'(flt));
    chk({tag, ".rom_addr"}, 32'(w_rom_addr), 32'(addr));
  endtask

  initial begin
    r_reset = 1'b1; r_clear = 1'b0; r_load = 1'b0; r_stall = 1'b0; r_in = '0;
    tick(); tick();
    chk_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 15'h0000);
    r_reset = 1'b0;

    // Sequential fetch from address 0
    for (int j = 0; j < 5; j++) begin
      tick();
      chk_out($sformatf("seq%0d", j), 16'h1000 + 16'(j), 16'(j), 1'b1, 1'b0, 15'(j + 1));
    end

    // Clear restarts at 0 but keeps the last instruction visible
    r_clear = 1'b1; tick(); r_clear = 1'b0;
    chk_out("clear", 16'h1004, 16'h0004, 1'b0, 1'b0, 15'h0000);
    tick(); tick(); tick();
    chk_out("refetch", 16'h1002, 16'h0002, 1'b1, 1'b0, 15'h0003);

    // Jump from pc=3 to 0x100
    r_load = 1'b1; r_in = 16'h0100; tick(); r_load = 1'b0;
    chk_out("jump.bubble", 16'h1002, 16'h0002, 1'b0, 1'b0, 15'h0100);
    tick();
    chk_out("jump.target", 16'h1100, 16'h0100, 1'b1, 1'b0, 15'h0101);

    // Stall at pc=2 with a live instruction
    r_load = 1'b1; r_in = 16'h0001; tick(); r_load = 1'b0;
    tick();
    chk_out("pre_stall", 16'h1001, 16'h0001, 1'b1, 1'b0, 15'h0002);
    r_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_out($sformatf("stall%0d", j), 16'h1001, 16'h0001, 1'b1, 1'b0, 15'h0002);
    end
    r_stall = 1'b0; tick();
    chk_out("unstall", 16'h1002, 16'h0002, 1'b1, 1'b0, 15'h0003);

    // Load overrides stall
    r_stall = 1'b1; r_load = 1'b1; r_in = 16'h0007; tick(); r_load = 1'b0;
    chk_out("load_stall", 16'h1002, 16'h0002, 1'b0, 1'b0, 15'h0007);
    tick();
    chk_out("load_stall.hold", 16'h1002, 16'h0002, 1'b0, 1'b0, 15'h0007);
    r_stall = 1'b0; tick();
    chk_out("load_stall.go", 16'h1007, 16'h0007, 1'b1, 1'b0, 15'h0008);

    // Run off the top of ROM into the fault state
    r_load = 1'b1; r_in = 16'h7FFE; tick(); r_load = 1'b0;
    tick();
    chk_out("top0", 16'h8FFE, 16'h7FFE, 1'b1, 1'b0, 15'h7FFF);
    tick();
    chk_out("top1", 16'h8FFF, 16'h7FFF, 1'b1, 1'b0, 15'h0000);
    tick();
    chk_out("fault", 16'h8FFF, 16'h7FFF, 1'b0, 1'b1, 15'h0000);
    r_load = 1'b1; r_in = 16'h0005; tick(); r_load = 1'b0;
    chk_out("fault.load", 16'h8FFF, 16'h7FFF, 1'b0, 1'b1, 15'h0000);
    tick();
    chk_out("fault.hold", 16'h8FFF, 16'h7FFF, 1'b0, 1'b1, 15'h0000);
    r_clear = 1'b1; tick(); r_clear = 1'b0;
    chk_out("fault.clear", 16'h8FFF, 16'h7FFF, 1'b0, 1'b0, 15'h0000);
    tick();
    chk_out("fault.rom0", 16'h1000, 16'h0000, 1'b1, 1'b0, 15'h0001);

    // Clear beats load on the same edge
    tick(); tick();
    r_clear = 1'b1; r_load = 1'b1; r_in = 16'h0020; tick();
    r_clear = 1'b0; r_load = 1'b0;
    chk_out("clr_load", 16'h1002, 16'h0002, 1'b0, 1'b0, 15'h0000);
    tick();
    chk_out("clr_load.next", 16'h1000, 16'h0000, 1'b1, 1'b0, 15'h0001);

    // Asynchronous reset mid-cycle while fetching at pc=9
    for (int j = 0; j < 8; j++) tick();
    chk_out("pre_reset", 16'h1008, 16'h0008, 1'b1, 1'b0, 15'h0009);
    #2 r_reset = 1'b1;
    #1;
    chk_out("async_reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 15'h0000);
    tick();
    r_reset = 1'b0;
    chk_out("reset_hold", 16'h0000, 16'h0000, 1'b0, 1'b0, 15'h0000);
    tick();
    chk_out("post_reset", 16'h1000, 16'h0000, 1'b1, 1'b0, 15'h0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
